// File: rtl/comm_ber_align.sv
`default_nettype none
// ============================================================================
// comm_ber_align : AD/valid delay alignment plus reference FIFO bit-error monitor
// Revision: 1.0
// ============================================================================
module comm_ber_align #(
  parameter int NCH       = 2,
  parameter int AD_W      = 8,
  parameter int SEL_W     = 4,
  parameter int DATA_DMIN = 1,
  parameter int VAL_DMIN  = 24,
  parameter int RAW_W     = 6,
  parameter int DEPTH_LG  = 5,
  parameter int CNT_W     = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCH*AD_W-1:0]   ad,
  input  logic [NCH*SEL_W-1:0]  ad_delay,
  input  logic                  da_valid,
  input  logic [SEL_W-1:0]      valid_delay,
  output logic [NCH*AD_W-1:0]   ad_dl,
  output logic                  ad_valid,
  input  logic                  send_valid,
  input  logic [RAW_W-1:0]      send_raw,
  input  logic                  recv_valid,
  input  logic [RAW_W-1:0]      recv_raw,
  output logic [RAW_W-1:0]      ref_raw,
  output logic                  cmp_valid,
  output logic                  cmp_err,
  output logic [DEPTH_LG:0]     level,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      sym_cnt,
  output logic [CNT_W-1:0]      sym_err_cnt,
  output logic [CNT_W-1:0]      bit_err_cnt,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DATA_LEN = DATA_DMIN + (1 << SEL_W) - 1;
  localparam int VAL_LEN  = VAL_DMIN + (1 << SEL_W) - 1;
  localparam int DIDX_W   = $clog2(DATA_LEN);
  localparam int VIDX_W   = $clog2(VAL_LEN);
  localparam int DEPTH    = 1 << DEPTH_LG;
  localparam int POP_W    = $clog2(RAW_W + 1);

  // Stage i holds the sample taken i+1 cycles ago, so a delay of d reads stage d-1.
  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      logic [AD_W-1:0]   dl_q [DATA_LEN];
      logic [AD_W-1:0]   dl_d [DATA_LEN];
      logic [DIDX_W-1:0] tap;

      always_comb begin
        dl_d[0] = ad[k*AD_W +: AD_W];
        for (int i = 1; i < DATA_LEN; i++) dl_d[i] = dl_q[i-1];
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < DATA_LEN; i++) dl_q[i] <= '0;
        end else begin
          for (int i = 0; i < DATA_LEN; i++) dl_q[i] <= dl_d[i];
        end
      end

      assign tap = DIDX_W'(DATA_DMIN - 1) + DIDX_W'(ad_delay[k*SEL_W +: SEL_W]);
      assign ad_dl[k*AD_W +: AD_W] = dl_q[tap];
    end
  endgenerate

  logic [VAL_LEN-1:0] vl_q, vl_d;
  logic [VIDX_W-1:0]  vtap;

  assign vl_d     = {vl_q[VAL_LEN-2:0], da_valid};
  assign vtap     = VIDX_W'(VAL_DMIN - 1) + VIDX_W'(valid_delay);
  assign ad_valid = vl_q[vtap];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) vl_q <= '0;
    else      vl_q <= vl_d;
  end

  logic [RAW_W-1:0]    mem_q [DEPTH];
  logic [RAW_W-1:0]    mem_d [DEPTH];
  logic [DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LG:0]   count_q, count_d;
  logic                empty, full, do_push, do_pop;
  logic [RAW_W-1:0]    head, diff;
  logic [POP_W-1:0]    popcnt;

  logic [RAW_W-1:0]    ref_raw_q, ref_raw_d;
  logic                cmp_valid_q, cmp_valid_d, cmp_err_q, cmp_err_d;
  logic [POP_W-1:0]    bit_diff_q, bit_diff_d;

  // A pop frees the slot a same-cycle push needs, so push-while-full is legal then.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (DEPTH_LG+1)'(DEPTH));
    do_pop  = recv_valid && !empty;
    do_push = send_valid && (!full || do_pop);
    head    = mem_q[rd_ptr_q];
    diff    = head ^ recv_raw;

    popcnt = '0;
    for (int i = 0; i < RAW_W; i++) popcnt = popcnt + POP_W'(diff[i]);

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = send_raw;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ref_raw_d   = do_pop ? head : ref_raw_q;
    cmp_valid_d = do_pop;
    cmp_err_d   = do_pop && (diff != '0);
    bit_diff_d  = do_pop ? popcnt : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ref_raw_q   <= '0;
      cmp_valid_q <= 1'b0;
      cmp_err_q   <= 1'b0;
      bit_diff_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ref_raw_q   <= ref_raw_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_err_q   <= cmp_err_d;
      bit_diff_q  <= bit_diff_d;
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d, sym_err_cnt_q, sym_err_cnt_d;
  logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  // Clear wins over any increment or flag set landing in the same cycle.
  always_comb begin
    sym_cnt_d     = sym_cnt_q;
    sym_err_cnt_d = sym_err_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;
    ovf_d         = ovf_q | (send_valid && full && !recv_valid);
    udf_d         = udf_q | (recv_valid && empty);
    if (cmp_valid_q) begin
      sym_cnt_d     = sat_add(sym_cnt_q, CNT_W'(1));
      sym_err_cnt_d = sat_add(sym_err_cnt_q, CNT_W'(cmp_err_q));
      bit_err_cnt_d = sat_add(bit_err_cnt_q, CNT_W'(bit_diff_q));
    end
    if (cnt_clear) begin
      sym_cnt_d     = '0;
      sym_err_cnt_d = '0;
      bit_err_cnt_d = '0;
      ovf_d         = 1'b0;
      udf_d         = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sym_cnt_q     <= '0;
      sym_err_cnt_q <= '0;
      bit_err_cnt_q <= '0;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
    end else begin
      sym_cnt_q     <= sym_cnt_d;
      sym_err_cnt_q <= sym_err_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
    end
  end

  assign ref_raw     = ref_raw_q;
  assign cmp_valid   = cmp_valid_q;
  assign cmp_err     = cmp_err_q;
  assign level       = count_q;
  assign sym_cnt     = sym_cnt_q;
  assign sym_err_cnt = sym_err_cnt_q;
  assign bit_err_cnt = bit_err_cnt_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

endmodule
`default_nettype wire
